epu_axi_burst_master: RTL and testbench

AXI4 burst initiator for the EPU subsystem: accepts one read or write command at a time and executes it as a single INCR burst on an AXI master port. It is the requester-side counterpart of the EPU slave wrapper. It lets the EPU fetch operands from system memory and write results back, without CPU-driven transfers. Write data is consumed from a local stream, and read data is delivered on a local stream.

---
 rtl/epu_axi_burst_master_if.sv | 68 ++++++
 rtl/epu_axi_burst_master.sv | 188 ++++++++++++++++++
 tb/tb_epu_axi_burst_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epu_axi_burst_master_if.sv
// AXI4 master-port bundle for the EPU burst initiator.
// Holds the AW/W/B/AR/R channels, with modports for the master side and the slave side.
interface epu_axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/epu_axi_burst_master.sv
// EPU AXI4 burst initiator: runs one read or write command at a time as a single INCR burst.
// Write data comes from a local stream; read data is passed straight through to a local stream.
module epu_axi_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_write_i,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [ID_W-1:0]    cmd_id_i,
    input  logic [DATA_W-1:0]  wd_data_i,
    input  logic               wd_valid_i,
    output logic               wd_ready_o,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic               done_o,
    output logic               err_o,
    epu_axi_burst_master_if.master axi
);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [ID_W-1:0]     id_r;
    logic                awvalid_r;
    logic                arvalid_r;
    logic                done_r;
    logic                err_r;
    logic                err_flag_r;

    logic                r_hs_s;
    logic                w_hs_s;
    logic                final_s;
    logic                r_err_s;

    // A read beat is bad on a non-OKAY response or when rlast disagrees with the beat count.
    function automatic logic r_beat_err(input logic [1:0] resp, input logic last, input logic final_beat);
        return (resp != RESP_OKAY) || (last != final_beat);
    endfunction

    // Handshake and beat-position decode.
    always_comb begin
        final_s = (cnt_r == len_r);
        r_hs_s  = (state_r == ST_R) && axi.rvalid && rd_ready_i;
        w_hs_s  = (state_r == ST_W) && wd_valid_i && axi.wready;
        r_err_s = r_beat_err(axi.rresp, axi.rlast, final_s);
    end

    // Stream and AXI output drive; data paths are zero-cycle pass-throughs gated by state.
    always_comb begin
        cmd_ready_o = (state_r == ST_IDLE);

        axi.awid    = id_r;
        axi.awaddr  = addr_r;
        axi.awlen   = len_r;
        axi.awsize  = SIZE_4B;
        axi.awburst = BURST_INCR;
        axi.awvalid = awvalid_r;

        axi.arid    = id_r;
        axi.araddr  = addr_r;
        axi.arlen   = len_r;
        axi.arsize  = SIZE_4B;
        axi.arburst = BURST_INCR;
        axi.arvalid = arvalid_r;

        axi.wdata   = wd_data_i;
        axi.wstrb   = {(DATA_W/8){1'b1}};
        axi.wlast   = (state_r == ST_W) && final_s;
        axi.wvalid  = (state_r == ST_W) && wd_valid_i;
        wd_ready_o  = (state_r == ST_W) && axi.wready;

        axi.bready  = (state_r == ST_B);

        axi.rready  = (state_r == ST_R) && rd_ready_i;
        rd_valid_o  = (state_r == ST_R) && axi.rvalid;
        rd_data_o   = axi.rdata;

        done_o      = done_r;
        err_o       = err_r;
    end

    // Burst sequencer: command latch, address phase, data phase and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            id_r       <= {ID_W{1'b0}};
            awvalid_r  <= 1'b0;
            arvalid_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_flag_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_r     <= cmd_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
                        len_r      <= cmd_len_i;
                        id_r       <= cmd_id_i;
                        err_flag_r <= 1'b0;
                        if (cmd_write_i) begin
                            state_r   <= ST_AW;
                            awvalid_r <= 1'b1;
                        end else begin
                            state_r   <= ST_AR;
                            arvalid_r <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        arvalid_r <= 1'b0;
                        cnt_r     <= {LEN_W{1'b0}};
                        state_r   <= ST_R;
                    end
                end
                ST_AW: begin
                    if (axi.awready) begin
                        awvalid_r <= 1'b0;
                        cnt_r     <= {LEN_W{1'b0}};
                        state_r   <= ST_W;
                    end
                end
                ST_R: begin
                    if (r_hs_s) begin
                        if (r_err_s) begin
                            err_flag_r <= 1'b1;
                        end
                        if (final_s) begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                            err_r   <= err_flag_r | r_err_s;
                        end else begin
                            cnt_r <= cnt_r + LEN_W'(1'b1);
                        end
                    end
                end
                ST_W: begin
                    if (w_hs_s) begin
                        if (final_s) begin
                            state_r <= ST_B;
                        end else begin
                            cnt_r <= cnt_r + LEN_W'(1'b1);
                        end
                    end
                end
                ST_B: begin
                    if (axi.bvalid) begin
                        state_r    <= ST_IDLE;
                        done_r     <= 1'b1;
                        err_r      <= err_flag_r | (axi.bresp != RESP_OKAY);
                        err_flag_r <= err_flag_r | (axi.bresp != RESP_OKAY);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    awvalid_r <= 1'b0;
                    arvalid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_epu_axi_burst_master.sv
// Self-checking bench for epu_axi_burst_master: scripted AXI slave plus data scoreboards.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_epu_axi_burst_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [3:0]  cmd_len_i;
    logic [3:0]  cmd_id_i;
    logic [31:0] wd_data_i;
    logic        wd_valid_i;
    logic        wd_ready_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];

    epu_axi_burst_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(4)) axi ();

    epu_axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
        .wd_data_i(wd_data_i), .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .done_o(done_o), .err_o(err_o), .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'h0; cmd_len_i = 4'h0; cmd_id_i = 4'h0;
        wd_data_i = 32'h0; wd_valid_i = 1'b0; rd_ready_i = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = 4'h0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rid = 4'h0; axi.rdata = 32'h0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        axi.rvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || rd_valid_o !== 1'b0 ||
            wd_ready_o !== 1'b0 || axi.awvalid !== 1'b0 || axi.arvalid !== 1'b0 || axi.wvalid !== 1'b0 ||
            axi.bready !== 1'b0 || axi.rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got cmd_rdy=%b done=%b err=%b rdv=%b wdr=%b awv=%b arv=%b wv=%b br=%b rr=%b, want 1 0 0 0 0 0 0 0 0 0",
                     cmd_ready_o, done_o, err_o, rd_valid_o, wd_ready_o, axi.awvalid, axi.arvalid,
                     axi.wvalid, axi.bready, axi.rready);
        end
        checks++;
        if (axi.araddr !== 32'h0 || axi.awaddr !== 32'h0 || axi.arlen !== 4'h0 || axi.awid !== 4'h0 ||
            axi.awsize !== 3'b010 || axi.arsize !== 3'b010 || axi.awburst !== 2'b01 || axi.arburst !== 2'b01) begin
            errors++;
            $display("FAIL reset_payload: got araddr=%h awaddr=%h arlen=%h awid=%h awsize=%b arsize=%b awburst=%b arburst=%b, want 0 0 0 0 010 010 01 01",
                     axi.araddr, axi.awaddr, axi.arlen, axi.awid, axi.awsize, axi.arsize, axi.awburst, axi.arburst);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_read(input string name, input logic [31:0] addr, input logic [3:0] len,
                           input int ar_wait, input int err_beat, input int bad_last_beat,
                           input logic stall, input logic exp_err);
        int cyc;
        logic [31:0] exp_d;
        rd_q.delete();
        for (int b = 0; b <= int'(len); b++) rd_q.push_back(32'h0000_00A0 + 32'(b));
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = addr; cmd_len_i = len; cmd_id_i = 4'h3;
        rd_ready_i = 1'b1;
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL %s_cmd_ready: got %b want 1", name, cmd_ready_o);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        cyc = 1;
        for (int i = 0; i <= ar_wait; i++) begin
            axi.arready = (i == ar_wait);
            #1;
            checks++;
            if (axi.arvalid !== 1'b1 || axi.araddr !== (addr & 32'hFFFF_FFFC) || axi.arlen !== len ||
                axi.arid !== 4'h3 || axi.rready !== 1'b0 || axi.awvalid !== 1'b0) begin
                errors++;
                $display("FAIL %s_ar_phase%0d: got arvalid=%b araddr=%h arlen=%h arid=%h rready=%b awvalid=%b, want 1 %h %h 3 0 0",
                         name, i, axi.arvalid, axi.araddr, axi.arlen, axi.arid, axi.rready, axi.awvalid,
                         addr & 32'hFFFF_FFFC, len);
            end
            @(negedge clk);
            cyc++;
        end
        axi.arready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 32'h0000_00A0 + 32'(b);
            axi.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            axi.rlast  = (b == bad_last_beat) ? (b != int'(len)) : (b == int'(len));
            if (stall && b == 1) begin
                rd_ready_i = 1'b0;
                #1;
                checks++;
                if (axi.rready !== 1'b0 || rd_valid_o !== 1'b1) begin
                    errors++; $display("FAIL %s_stall: got rready=%b rd_valid=%b want 0 1", name, axi.rready, rd_valid_o);
                end
                @(negedge clk);
                cyc++;
                rd_ready_i = 1'b1;
            end
            #1;
            exp_d = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            checks++;
            if (rd_valid_o !== 1'b1 || axi.rready !== 1'b1 || rd_data_o !== exp_d || done_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_beat%0d: got rd_valid=%b rready=%b data=%h done=%b, want 1 1 %h 0",
                         name, b, rd_valid_o, axi.rready, rd_data_o, done_o, exp_d);
            end
            @(negedge clk);
            cyc++;
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        #1;
        checks++;
        if (done_o !== 1'b1 || err_o !== exp_err || cmd_ready_o !== 1'b1 ||
            cyc != ar_wait + int'(len) + 3 + int'(stall)) begin
            errors++;
            $display("FAIL %s_done: got done=%b err=%b cmd_ready=%b latency=%0d, want 1 %b 1 %0d",
                     name, done_o, err_o, cmd_ready_o, cyc, exp_err, ar_wait + int'(len) + 3 + int'(stall));
        end
        @(negedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse: got done=%b err=%b want 0 0", name, done_o, err_o);
        end
    endtask

    task automatic do_write(input string name, input logic [31:0] addr, input logic [3:0] len,
                            input logic toggle, input logic [1:0] bresp, input int rst_beat);
        int beat;
        int cyc;
        logic [31:0] exp_d;
        wr_q.delete();
        for (int b = 0; b <= int'(len); b++) wr_q.push_back(32'(b));
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = addr; cmd_len_i = len; cmd_id_i = 4'h5;
        wd_valid_i = 1'b1; wd_data_i = 32'h0;
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL %s_cmd_ready: got %b want 1", name, cmd_ready_o);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        axi.awready = 1'b1;
        #1;
        checks++;
        if (axi.awvalid !== 1'b1 || axi.awlen !== len || axi.awaddr !== (addr & 32'hFFFF_FFFC) ||
            axi.awid !== 4'h5 || axi.wvalid !== 1'b0 || wd_ready_o !== 1'b0 || axi.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_aw_phase: got awvalid=%b awlen=%h awaddr=%h awid=%h wvalid=%b wd_ready=%b arvalid=%b, want 1 %h %h 5 0 0 0",
                     name, axi.awvalid, axi.awlen, axi.awaddr, axi.awid, axi.wvalid, wd_ready_o, axi.arvalid,
                     len, addr & 32'hFFFF_FFFC);
        end
        @(negedge clk);
        axi.awready = 1'b0;
        beat = 0;
        cyc = 0;
        while (beat <= int'(len) && cyc < 64) begin
            axi.wready = toggle ? (cyc % 2 == 0) : 1'b1;
            wd_data_i  = 32'(beat);
            wd_valid_i = 1'b1;
            if (beat == rst_beat) begin
                #1;
                rst = 1'b0;
                #1;
                checks++;
                if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0 || wd_ready_o !== 1'b0 || done_o !== 1'b0 ||
                    axi.bready !== 1'b0 || cmd_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_async_rst: got awvalid=%b wvalid=%b wd_ready=%b done=%b bready=%b cmd_ready=%b, want 0 0 0 0 0 1",
                             name, axi.awvalid, axi.wvalid, wd_ready_o, done_o, axi.bready, cmd_ready_o);
                end
                @(negedge clk);
                wd_valid_i = 1'b0; axi.wready = 1'b0;
                rst = 1'b1;
                return;
            end
            #1;
            checks++;
            if (axi.wvalid !== 1'b1 || wd_ready_o !== axi.wready || axi.wstrb !== 4'hF || axi.awvalid !== 1'b0) begin
                errors++;
                $display("FAIL %s_w_ctrl%0d: got wvalid=%b wd_ready=%b wready=%b wstrb=%h awvalid=%b, want 1 =wready F 0",
                         name, cyc, axi.wvalid, wd_ready_o, axi.wready, axi.wstrb, axi.awvalid);
            end
            if (axi.wready) begin
                exp_d = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (axi.wdata !== exp_d || axi.wlast !== (beat == int'(len))) begin
                    errors++;
                    $display("FAIL %s_w_beat%0d: got wdata=%h wlast=%b, want %h %b",
                             name, beat, axi.wdata, axi.wlast, exp_d, beat == int'(len));
                end
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (beat <= int'(len)) begin
            errors++; $display("FAIL %s_w_timeout: got %0d beats want %0d", name, beat, int'(len) + 1);
        end
        axi.wready = 1'b0; wd_valid_i = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = bresp; axi.bid = 4'h5;
        #1;
        checks++;
        if (axi.bready !== 1'b1 || axi.wvalid !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_b_phase: got bready=%b wvalid=%b done=%b want 1 0 0", name, axi.bready, axi.wvalid, done_o);
        end
        @(negedge clk);
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        #1;
        checks++;
        if (done_o !== 1'b1 || err_o !== (bresp != 2'b00) || cmd_ready_o !== 1'b1 ||
            (!toggle && cyc != int'(len) + 1)) begin
            errors++;
            $display("FAIL %s_done: got done=%b err=%b cmd_ready=%b w_cycles=%0d, want 1 %b 1 %0d",
                     name, done_o, err_o, cmd_ready_o, cyc, bresp != 2'b00, int'(len) + 1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse: got done=%b err=%b want 0 0", name, done_o, err_o);
        end
    endtask

    task automatic test_read();
        do_read("read_len3", 32'h5000_0010, 4'd3, 0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_write_toggle();
        do_write("write_len7", 32'h5000_0100, 4'd7, 1'b1, 2'b00, -1);
    endtask

    task automatic test_ar_backpressure();
        do_read("ar_bp", 32'h5000_0040, 4'd0, 5, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_read_slverr();
        do_read("read_slverr", 32'h5000_0020, 4'd1, 0, 1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_read_bad_last();
        do_read("read_early_last", 32'h5000_0080, 4'd1, 0, -1, 0, 1'b0, 1'b1);
        do_read("read_missing_last", 32'h5000_0090, 4'd2, 0, -1, 2, 1'b0, 1'b1);
    endtask

    task automatic test_read_stall();
        do_read("read_stall", 32'h5000_00C0, 4'd2, 0, -1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_write_slverr();
        do_write("write_slverr", 32'h5000_0200, 4'd2, 1'b0, 2'b10, -1);
    endtask

    task automatic test_reset_mid_burst();
        do_write("write_rst", 32'h5000_0300, 4'd5, 1'b0, 2'b00, 2);
        do_read("read_after_rst", 32'h5000_0400, 4'd2, 0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned();
        do_read("misaligned", 32'h5000_0003, 4'd0, 0, -1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_toggle();
        test_ar_backpressure();
        test_read_slverr();
        test_read_bad_last();
        test_read_stall();
        test_write_slverr();
        test_reset_mid_burst();
        test_misaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
